// File: rtl/seg_pkg.sv
// Shared constants, glyph table and scan-state encoding for the
// 8-digit 7-segment scan controller.
package seg_pkg;

   localparam int NUM_DIGITS = 8;

   // Segment order {a,b,c,d,e,f,g}; a segment is lit when its bit is 0.
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_r     = 7'b1111010;
   localparam logic [6:0] SEG_P     = 7'b0011000;
   localparam logic [6:0] SEG_DIG [1:8] = '{
      7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
      7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000
   };

   typedef enum logic [1:0] {
      IDLE,
      BLANK,
      DRIVE
   } scan_state_t;

   function automatic logic [6:0] num_glyph(input int n);
      logic [6:0] g;
      g = SEG_BLANK;
      case (n)
         1: g = SEG_DIG[1];
         2: g = SEG_DIG[2];
         3: g = SEG_DIG[3];
         4: g = SEG_DIG[4];
         5: g = SEG_DIG[5];
         6: g = SEG_DIG[6];
         7: g = SEG_DIG[7];
         8: g = SEG_DIG[8];
         default: g = SEG_BLANK;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational cathode pattern for the digit being scanned, built from the
// per-frame snapshot of clip number, mode and busy plus the blink phase.
module seg7_glyph_decode
   import seg_pkg::*;
#(
   parameter int CLIP_W = 3
) (
   input  logic [2:0]        i_digit,
   input  logic [CLIP_W-1:0] i_clip,
   input  logic              i_rec,
   input  logic              i_busy,
   input  logic              i_blink_phase,
   output logic [6:0]        o_cathode
);

   logic [6:0] w_digit0;
   logic [6:0] w_digit7;

   // Clips are 0-based internally but shown to the user as 1..8.
   assign w_digit0 = num_glyph(int'(i_clip) + 1);
   assign w_digit7 = (i_busy && i_blink_phase) ? SEG_BLANK : (i_rec ? SEG_r : SEG_P);

   always_comb begin
      o_cathode = SEG_BLANK;
      case (i_digit)
         3'd0:    o_cathode = w_digit0;
         3'd7:    o_cathode = w_digit7;
         default: o_cathode = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg_scan_controller.sv
// Time-multiplexed anode/cathode scanner for the clip recorder display:
// blank gap then drive per digit slot, inputs snapshotted once per frame.
module seg_scan_controller
   import seg_pkg::*;
#(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 16,
   parameter int BLINK_FRAMES = 64,
   parameter int CLIP_W       = 3
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic [CLIP_W-1:0] clip_num,
   input  logic              record_or_play,
   input  logic              busy,
   output logic [6:0]        cathode,
   output logic [7:0]        anode,
   output logic              frame_start
);

   localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam int DIG_W = $clog2(NUM_DIGITS);
   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(REFRESH_DIV - 1);
   localparam logic [DIV_W-1:0] BLANK_LAST = DIV_W'(BLANK_CYCLES - 1);
   localparam logic [FRM_W-1:0] FRM_LAST   = FRM_W'(BLINK_FRAMES - 1);
   localparam logic [DIG_W-1:0] DIG_LAST   = DIG_W'(NUM_DIGITS - 1);

   scan_state_t       r_state;
   logic [DIV_W-1:0]  r_div_cnt;
   logic [DIG_W-1:0]  r_digit;
   logic [FRM_W-1:0]  r_frame_cnt;
   logic              r_blink_phase;
   logic [CLIP_W-1:0] r_snap_clip;
   logic              r_snap_rec;
   logic              r_snap_busy;
   logic [6:0]        r_cathode;
   logic [7:0]        r_anode;
   logic              r_frame_start;

   scan_state_t       w_state_nxt;
   logic [DIV_W-1:0]  w_div_nxt;
   logic [DIG_W-1:0]  w_digit_nxt;
   logic              w_wrap;
   logic              w_start;
   logic              w_drive;
   logic [6:0]        w_glyph;
   logic [7:0]        w_anode_nxt;
   logic [6:0]        w_cathode_nxt;

   seg7_glyph_decode #(
      .CLIP_W (CLIP_W)
   ) u_glyph (
      .i_digit       (r_digit),
      .i_clip        (r_snap_clip),
      .i_rec         (r_snap_rec),
      .i_busy        (r_snap_busy),
      .i_blink_phase (r_blink_phase),
      .o_cathode     (w_glyph)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_div_nxt   = r_div_cnt;
      w_digit_nxt = r_digit;
      w_wrap      = 1'b0;
      w_start     = 1'b0;
      w_drive     = 1'b0;
      if (!enable) begin
         w_state_nxt = IDLE;
         w_div_nxt   = '0;
         w_digit_nxt = '0;
      end else begin
         case (r_state)
            IDLE: begin
               w_state_nxt = BLANK;
               w_div_nxt   = '0;
               w_digit_nxt = '0;
               w_start     = 1'b1;
            end
            BLANK: begin
               w_div_nxt = r_div_cnt + 1'b1;
               if (r_div_cnt == BLANK_LAST) w_state_nxt = DRIVE;
            end
            DRIVE: begin
               w_drive = 1'b1;
               if (r_div_cnt == DIV_LAST) begin
                  w_div_nxt   = '0;
                  w_digit_nxt = r_digit + 1'b1;
                  w_state_nxt = BLANK;
                  if (r_digit == DIG_LAST) begin
                     w_wrap  = 1'b1;
                     w_start = 1'b1;
                  end
               end else begin
                  w_div_nxt = r_div_cnt + 1'b1;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // Dropping enable blanks the pins on the very next cycle, not one slot later.
   assign w_anode_nxt   = w_drive ? ~(8'(1) << r_digit) : 8'hFF;
   assign w_cathode_nxt = w_drive ? w_glyph : SEG_BLANK;

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state       <= IDLE;
         r_div_cnt     <= '0;
         r_digit       <= '0;
         r_frame_cnt   <= '0;
         r_blink_phase <= 1'b0;
         r_anode       <= 8'hFF;
         r_cathode     <= SEG_BLANK;
         r_frame_start <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_div_cnt     <= w_div_nxt;
         r_digit       <= w_digit_nxt;
         r_anode       <= w_anode_nxt;
         r_cathode     <= w_cathode_nxt;
         r_frame_start <= w_start;
         if (w_wrap) begin
            if (r_frame_cnt == FRM_LAST) begin
               r_frame_cnt   <= '0;
               r_blink_phase <= ~r_blink_phase;
            end else begin
               r_frame_cnt <= r_frame_cnt + 1'b1;
            end
         end
      end
   end

   // Snapshot is always refreshed on leaving IDLE before it is ever displayed.
   always_ff @(posedge clock) begin
      if (w_start) begin
         r_snap_clip <= clip_num;
         r_snap_rec  <= record_or_play;
         r_snap_busy <= busy;
      end
   end

   assign anode       = r_anode;
   assign cathode     = r_cathode;
   assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Bench for seg_scan_controller: directed scenarios plus random input
// traffic, compared each cycle against a position-based display model.
module tb_seg_scan_controller;

   localparam int R  = 8;
   localparam int B  = 2;
   localparam int BF = 2;
   localparam int CW = 3;
   localparam int FRAME = 8 * R;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          enable = 1'b0;
   logic [CW-1:0] clip_num = '0;
   logic          record_or_play = 1'b0;
   logic          busy = 1'b0;
   logic [6:0]    cathode;
   logic [7:0]    anode;
   logic          frame_start;

   int n_checks = 0;
   int n_errors = 0;

   seg_scan_controller #(
      .REFRESH_DIV  (R),
      .BLANK_CYCLES (B),
      .BLINK_FRAMES (BF),
      .CLIP_W       (CW)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .enable         (enable),
      .clip_num       (clip_num),
      .record_or_play (record_or_play),
      .busy           (busy),
      .cathode        (cathode),
      .anode          (anode),
      .frame_start    (frame_start)
   );

   always #5 clock = ~clock;

   // Reference: position within the frame since scanning started, plus a
   // running count of completed frames since reset.
   bit         m_active = 1'b0;
   int         m_pos = 0;
   int         m_wraps = 0;
   int         m_clip = 0;
   bit         m_rec = 1'b0;
   bit         m_busy = 1'b0;
   logic [7:0] e_anode;
   logic [6:0] e_cath;
   logic       e_fs;
   logic [6:0] num_tab [0:7] = '{
      7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
      7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000
   };

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic take_snap();
      m_clip = int'(clip_num);
      m_rec  = record_or_play;
      m_busy = busy;
   endtask

   task automatic model_edge();
      int d;
      int s;
      e_anode = 8'hFF;
      e_cath  = 7'h7F;
      e_fs    = 1'b0;
      if (!reset) begin
         m_active = 1'b0;
         m_pos    = 0;
         m_wraps  = 0;
      end else if (!enable) begin
         m_active = 1'b0;
      end else if (!m_active) begin
         m_active = 1'b1;
         m_pos    = 0;
         e_fs     = 1'b1;
         take_snap();
      end else begin
         d = (m_pos / R) % 8;
         s = m_pos % R;
         if (s >= B) begin
            e_anode = ~(8'h01 << d);
            if (d == 0)
               e_cath = num_tab[m_clip];
            else if (d == 7)
               e_cath = (m_busy && ((m_wraps / BF) % 2 == 1)) ? 7'h7F
                        : (m_rec ? 7'b1111010 : 7'b0011000);
         end
         if (m_pos == FRAME - 1) begin
            e_fs = 1'b1;
            take_snap();
            m_wraps++;
            m_pos = 0;
         end else begin
            m_pos++;
         end
      end
   endtask

   task automatic tick();
      @(posedge clock);
      model_edge();
      #1;
      chk("anode", 32'(anode), 32'(e_anode));
      chk("cathode", 32'(cathode), 32'(e_cath));
      chk("frame_start", 32'(frame_start), 32'(e_fs));
      chk("onehot_anode", 32'($onehot0(~anode)), 32'd1);
   endtask

   // Advance until the model says the given digit is mid-DRIVE with its anode on the pins.
   task automatic run_to_drive(input int dig, input string tag);
      int n;
      n = 0;
      while (!(m_active && ((m_pos / R) % 8 == dig) && (m_pos % R >= B + 1)) && n < 1000) begin
         tick();
         n++;
      end
      chk(tag, 32'(n < 1000), 32'd1);
   endtask

   initial begin
      repeat (3) tick();

      reset = 1'b1;
      enable = 1'b1;
      clip_num = 3'd1;
      record_or_play = 1'b0;
      busy = 1'b0;
      repeat (2 * FRAME + 4) tick();

      run_to_drive(3, "reach_digit3");
      clip_num = 3'd4;
      repeat (2 * FRAME) tick();

      busy = 1'b1;
      record_or_play = 1'b1;
      repeat (6 * FRAME) tick();

      run_to_drive(2, "reach_abort");
      enable = 1'b0;
      repeat (3) tick();
      enable = 1'b1;
      repeat (FRAME + 4) tick();

      run_to_drive(5, "reach_digit5");
      reset = 1'b0;
      tick();
      reset = 1'b1;
      repeat (FRAME) tick();

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) == 0) enable = ~enable;
         reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
         if ($urandom_range(0, 19) == 0) clip_num = CW'($urandom);
         if ($urandom_range(0, 39) == 0) record_or_play = ~record_or_play;
         if ($urandom_range(0, 39) == 0) busy = ~busy;
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
